// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR register file:
// CSR addresses, mstatus/mcountinhibit bit positions and a read helper.
package csr_pkg;

    localparam int XLEN = 64;

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MCNTINH   = 12'h320;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
    localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam int MCNTINH_CY = 0;
    localparam int MCNTINH_IR = 2;

    // Assemble the architectural mstatus view; MPP is fixed at M-mode.
    function automatic logic [XLEN-1:0] mstatus_view(input logic mie,
                                                      input logic mpie);
        logic [XLEN-1:0] v;
        v = '0;
        v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        v[MSTATUS_MPIE] = mpie;
        v[MSTATUS_MIE]  = mie;
        return v;
    endfunction

endpackage

// File: rtl/csr_if.sv
// CSR access bundle between the CSR functional unit (master)
// and the CSR register file (slave): combinational read, commit write.
interface csr_if;
    import csr_pkg::*;

    logic [11:0]     raddr;
    logic [XLEN-1:0] rdata;
    logic [11:0]     waddr;
    logic [XLEN-1:0] wdata;
    logic            wvalid;

    modport master (
        output raddr, waddr, wdata, wvalid,
        input  rdata
    );

    modport slave (
        input  raddr, waddr, wdata, wvalid,
        output rdata
    );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit performance counter with load, increment and inhibit.
// A load in the same cycle replaces that cycle's increment.
module csr_counter64 (
    input  logic        clk,
    input  logic        rstn,
    input  logic        inc_i,
    input  logic        inhibit_i,
    input  logic        wvalid_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] value_o
);

    logic [63:0] cnt_q;
    logic [63:0] cnt_d;

    // Next value: load beats count; counting wraps naturally.
    always_comb begin
        cnt_d = cnt_q;
        if (wvalid_i)
            cnt_d = wdata_i;
        else if (inc_i && !inhibit_i)
            cnt_d = cnt_q + 64'd1;
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign value_o = cnt_q;

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR storage, counters and trap/mret state updates.
// Optional build macro: CSR_COUNTINHIBIT_EN adds mcountinhibit (0x320).
module csr_regfile
    import csr_pkg::*;
#(
    parameter logic [XLEN-1:0] HART_ID     = 64'd0,
    parameter logic [XLEN-1:0] MTVEC_RESET = 64'h8000_0000,
    parameter logic [XLEN-1:0] MISA_VALUE  = 64'h8000_0000_0014_1101
) (
    input  logic            clk,
    input  logic            rstn,
    csr_if.slave            csr_io,
    input  logic            retire_i_valid,
    input  logic            trap_i_valid,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_tval_i,
    input  logic            mret_i_valid,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            mie_o
);

    logic            mstat_mie_q,  mstat_mie_d;
    logic            mstat_mpie_q, mstat_mpie_d;
    logic [XLEN-1:0] mie_q,      mie_d;
    logic [XLEN-1:0] mtvec_q,    mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q,     mepc_d;
    logic [XLEN-1:0] mcause_q,   mcause_d;
    logic [XLEN-1:0] mtval_q,    mtval_d;
    logic [XLEN-1:0] mcycle, minstret;
    logic [XLEN-1:0] rdata;
    logic            inh_cy, inh_ir;
    logic            trap_state_busy;

    function automatic logic wr_hit(input logic [11:0] a);
        return csr_io.wvalid && (csr_io.waddr == a);
    endfunction

    // Trap or mret owns the trap-state CSRs for the cycle.
    assign trap_state_busy = trap_i_valid || mret_i_valid;

`ifdef CSR_COUNTINHIBIT_EN
    logic inh_cy_q, inh_ir_q;

    // mcountinhibit keeps only the CY and IR bits.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            inh_cy_q <= 1'b0;
            inh_ir_q <= 1'b0;
        end else if (wr_hit(ADDR_MCNTINH)) begin
            inh_cy_q <= csr_io.wdata[MCNTINH_CY];
            inh_ir_q <= csr_io.wdata[MCNTINH_IR];
        end
    end

    assign inh_cy = inh_cy_q;
    assign inh_ir = inh_ir_q;
`else
    assign inh_cy = 1'b0;
    assign inh_ir = 1'b0;
`endif

    csr_counter64 u_mcycle (
        .clk       (clk),
        .rstn      (rstn),
        .inc_i     (1'b1),
        .inhibit_i (inh_cy),
        .wvalid_i  (wr_hit(ADDR_MCYCLE)),
        .wdata_i   (csr_io.wdata),
        .value_o   (mcycle)
    );

    csr_counter64 u_minstret (
        .clk       (clk),
        .rstn      (rstn),
        .inc_i     (retire_i_valid),
        .inhibit_i (inh_ir),
        .wvalid_i  (wr_hit(ADDR_MINSTRET)),
        .wdata_i   (csr_io.wdata),
        .value_o   (minstret)
    );

    // Next-state: trap > mret > CSR write for trap-state CSRs.
    always_comb begin
        mstat_mie_d  = mstat_mie_q;
        mstat_mpie_d = mstat_mpie_q;
        mie_d        = mie_q;
        mtvec_d      = mtvec_q;
        mscratch_d   = mscratch_q;
        mepc_d       = mepc_q;
        mcause_d     = mcause_q;
        mtval_d      = mtval_q;

        if (wr_hit(ADDR_MIE))      mie_d      = csr_io.wdata;
        if (wr_hit(ADDR_MSCRATCH)) mscratch_d = csr_io.wdata;
        if (wr_hit(ADDR_MTVEC))    mtvec_d    = {csr_io.wdata[XLEN-1:2], 2'b00};

        if (trap_i_valid) begin
            mepc_d       = {trap_pc_i[XLEN-1:2], 2'b00};
            mcause_d     = trap_cause_i;
            mtval_d      = trap_tval_i;
            mstat_mpie_d = mstat_mie_q;
            mstat_mie_d  = 1'b0;
        end else if (mret_i_valid) begin
            mstat_mie_d  = mstat_mpie_q;
            mstat_mpie_d = 1'b1;
        end

        if (!trap_state_busy) begin
            if (wr_hit(ADDR_MSTATUS)) begin
                mstat_mie_d  = csr_io.wdata[MSTATUS_MIE];
                mstat_mpie_d = csr_io.wdata[MSTATUS_MPIE];
            end
            if (wr_hit(ADDR_MEPC))   mepc_d   = {csr_io.wdata[XLEN-1:2], 2'b00};
            if (wr_hit(ADDR_MCAUSE)) mcause_d = csr_io.wdata;
            if (wr_hit(ADDR_MTVAL))  mtval_d  = csr_io.wdata;
        end
    end

    // CSR state registers; reset overrides every concurrent event.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mstat_mie_q  <= 1'b0;
            mstat_mpie_q <= 1'b0;
            mie_q        <= '0;
            mtvec_q      <= MTVEC_RESET;
            mscratch_q   <= '0;
            mepc_q       <= '0;
            mcause_q     <= '0;
            mtval_q      <= '0;
        end else begin
            mstat_mie_q  <= mstat_mie_d;
            mstat_mpie_q <= mstat_mpie_d;
            mie_q        <= mie_d;
            mtvec_q      <= mtvec_d;
            mscratch_q   <= mscratch_d;
            mepc_q       <= mepc_d;
            mcause_q     <= mcause_d;
            mtval_q      <= mtval_d;
        end
    end

    // Zero-latency read mux; unimplemented addresses read 0.
    always_comb begin
        rdata = '0;
        case (csr_io.raddr)
            ADDR_MSTATUS:  rdata = mstatus_view(mstat_mie_q, mstat_mpie_q);
            ADDR_MISA:     rdata = MISA_VALUE;
            ADDR_MIE:      rdata = mie_q;
            ADDR_MTVEC:    rdata = mtvec_q;
`ifdef CSR_COUNTINHIBIT_EN
            ADDR_MCNTINH: begin
                rdata[MCNTINH_CY] = inh_cy;
                rdata[MCNTINH_IR] = inh_ir;
            end
`endif
            ADDR_MSCRATCH: rdata = mscratch_q;
            ADDR_MEPC:     rdata = mepc_q;
            ADDR_MCAUSE:   rdata = mcause_q;
            ADDR_MTVAL:    rdata = mtval_q;
            ADDR_MCYCLE,
            ADDR_CYCLE:    rdata = mcycle;
            ADDR_MINSTRET,
            ADDR_INSTRET:  rdata = minstret;
            ADDR_MHARTID:  rdata = HART_ID;
            default:       rdata = '0;
        endcase
    end

    assign csr_io.rdata = rdata;
    assign mtvec_o      = mtvec_q;
    assign mepc_o       = mepc_q;
    assign mie_o        = mstat_mie_q;

endmodule
